// File: rtl/fir_out_buffer.sv
// Purpose: first-word-fall-through sample FIFO between the FIR output and a ready-gated consumer.
// Latency: a pushed sample appears on DOUT/VOUT one clock after it is written; no DIN->DOUT path.
// Backpressure: RDY=0 holds the head sample; pushes into a full FIFO are dropped and counted.
module fir_out_buffer #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RST_n,
   input  logic                     VIN,
   input  logic [WIDTH-1:0]         DIN,
   input  logic                     RDY,
   input  logic                     CLR_OVF,
   output logic [WIDTH-1:0]         DOUT,
   output logic                     VOUT,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     FULL,
   output logic                     EMPTY,
   output logic                     OVF,
   output logic [7:0]               DROPS
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       drops_q, drops_d;

   logic             full, empty;
   logic             pop, push, drop;

   // Status flags come straight from the registered occupancy.
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
   // alongside it; an empty FIFO never pops, so there is no bypass.
   assign pop  = !empty && RDY;
   assign push = VIN && (!full || pop);
   assign drop = VIN && !push;

   // Next-state for storage, pointers, occupancy and overflow bookkeeping.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      drops_d  = drops_q;

      if (push) begin
         mem_d[wr_ptr_q] = DIN;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      // A drop in the clearing cycle is not lost: it becomes the first new drop.
      if (CLR_OVF) begin
         ovf_d   = drop;
         drops_d = drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (drops_q != 8'hFF) begin
            drops_d = drops_q + 8'd1;
         end
      end
   end

   // State registers; reset discards every stored sample.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         drops_q  <= 8'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         drops_q  <= drops_d;
      end
   end

   // Head sample is forced to zero while empty so nothing stale is ever presented.
   assign DOUT  = empty ? '0 : mem_q[rd_ptr_q];
   assign VOUT  = !empty;
   assign COUNT = count_q;
   assign FULL  = full;
   assign EMPTY = empty;
   assign OVF   = ovf_q;
   assign DROPS = drops_q;

endmodule
